// File: rtl/bitop_arbiter.sv
// ---------------------------------------------------------------------------
// bitop_arbiter
//
// Four requesters share one bitwise-operation unit. A round-robin arbiter
// picks one pending requester while idle, latches its operands, evaluates
// the selected bitwise operation and holds the registered result until the
// consumer accepts it. Only one transaction is in flight at a time.
//
// Opcodes: 00 a|b, 01 a&b, 10 a^b, 11 ~a (b ignored).
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   req_valid   [NREQ]          per-requester request strobe
//   req_ready   [NREQ]          per-requester accept (one-hot or zero)
//   req_a       [NREQ*WIDTH]    operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b       [NREQ*WIDTH]    operand B, packed as req_a
//   req_op      [NREQ*2]        opcode, requester i at [i*2 +: 2]
//   rsp_valid                   result valid
//   rsp_ready                   consumer accept for the result
//   rsp_id      [2]             requester index owning the result
//   rsp_data    [WIDTH]         registered result
//   done_count  [8]             completed responses, wraps 255 -> 0
//
// NREQ is fixed at 4 (2-bit requester id).
// ---------------------------------------------------------------------------
module bitop_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [7:0]            done_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    logic [1:0]       state;
    logic [1:0]       last_grant;

    // Operands captured on the accept cycle; inputs are not looked at again.
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic [1:0]       lat_op;
    logic [1:0]       lat_id;

    logic             grant_found;
    logic [1:0]       grant_id;
    logic [1:0]       cand;
    logic             accept;

    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] result;

    // -----------------------------------------------------------------------
    // Round-robin search starting just after the last completed requester.
    // The k=4 step lands back on last_grant itself, so a lone requester
    // can be granted repeatedly.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_found = 1'b0;
        grant_id    = last_grant;
        cand        = last_grant;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // Accept only in IDLE and never while reset is asserted.
    assign accept = (state == ST_IDLE) && grant_found && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id == 2'(i)) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_op = req_op[i*2 +: 2];
            end
        end
    end

    always_comb begin
        result = '0;
        case (lat_op)
            OP_OR:   result = lat_a | lat_b;
            OP_AND:  result = lat_a & lat_b;
            OP_XOR:  result = lat_a ^ lat_b;
            OP_NOT:  result = ~lat_a;
            default: result = '0;
        endcase
    end

    // rsp_valid is a pure decode of the state register.
    assign rsp_valid = (state == ST_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 2'd3;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= '0;
            lat_id     <= '0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            done_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_a  <= sel_a;
                        lat_b  <= sel_b;
                        lat_op <= sel_op;
                        lat_id <= grant_id;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data <= result;
                    rsp_id   <= lat_id;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    // Returning to IDLE (rather than accepting here) gives
                    // the 3-cycle minimum accept spacing.
                    if (rsp_ready) begin
                        last_grant <= rsp_id;
                        done_count <= done_count + 8'd1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitop_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bitop_arbiter
//
// Scenario tasks drive the arbiter and check cycle-exact behaviour inline.
// Each accepted transaction pushes its expected {id, data} onto a
// scoreboard queue; a negedge monitor pops and compares on every response
// handshake. Reset flushes the queue since in-flight work is discarded.
// ---------------------------------------------------------------------------
module tb_bitop_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [7:0]  req_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_data;
    logic [7:0]  done_count;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests_run    = 0;
    int   tests_failed = 0;

    bitop_arbiter #(.WIDTH(4), .NREQ(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] bitop_model(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic [1:0] op);
        case (op)
            2'b00:   return a | b;
            2'b01:   return a & b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [3:0] a,
                           input logic [3:0] b, input logic [1:0] op);
        req_a[id*4 +: 4]  = a;
        req_b[id*4 +: 4]  = b;
        req_op[id*2 +: 2] = op;
    endtask

    // Scoreboard monitor: compares every response handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else if (rsp_valid && rsp_ready) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: got id=%0d data=%b, required no response",
                         rsp_id, rsp_data);
            end else begin
                mon_e = sb_q.pop_front();
                if ({rsp_id, rsp_data} !== {mon_e.id, mon_e.data}) begin
                    tests_failed++;
                    $display("FAIL sb_response: got id=%0d data=%b, required id=%0d data=%b",
                             rsp_id, rsp_data, mon_e.id, mon_e.data);
                end
            end
        end
    end

    task automatic test_reset();
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_req_ready: got %b, required 0000", req_ready);
        end
        tick();
        tick();
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_req_ready_held: got %b, required 0000", req_ready);
        end
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_data, done_count} !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%b id=%0d data=%b cnt=%0d, required all 0",
                     rsp_valid, rsp_id, rsp_data, done_count);
        end
        req_valid = '0;
        rst = 1'b0;
        tick();
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got rsp_valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_basic();
        set_req(0, 4'b1010, 4'b1100, 2'b00);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        sb_q.push_back({2'd0, 4'b1110});
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL basic_grant: got %b, required 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        tests_run++;
        if ({req_ready, rsp_valid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL basic_exec: got ready=%b valid=%b, required 0000/0", req_ready, rsp_valid);
        end
        tick();
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 4'b1110}) begin
            tests_failed++;
            $display("FAIL basic_resp: got valid=%b id=%0d data=%b, required 1/0/1110",
                     rsp_valid, rsp_id, rsp_data);
        end
        tick();
        tests_run++;
        if (done_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL basic_done_count: got %0d, required 1", done_count);
        end
    endtask

    task automatic test_ops();
        logic [3:0] exp_d [3];
        exp_d[0] = 4'b1000;
        exp_d[1] = 4'b0110;
        exp_d[2] = 4'b0101;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(1, 4'b1010, 4'b1100, 2'(i + 1));
            req_valid = 4'b0010;
            sb_q.push_back({2'd1, exp_d[i]});
            #1;
            tests_run++;
            if (req_ready !== 4'b0010) begin
                tests_failed++;
                $display("FAIL ops_grant[%0d]: got %b, required 0010", i, req_ready);
            end
            tick();
            req_valid = '0;
            tick();
            tests_run++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, exp_d[i]}) begin
                tests_failed++;
                $display("FAIL ops_resp[%0d]: got valid=%b id=%0d data=%b, required 1/1/%b",
                         i, rsp_valid, rsp_id, rsp_data, exp_d[i]);
            end
            tick();
        end
        tests_run++;
        if (done_count !== 8'd4) begin
            tests_failed++;
            $display("FAIL ops_done_count: got %0d, required 4", done_count);
        end
    endtask

    task automatic test_round_robin();
        int g;
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 4'(i * 3 + 1), 4'(i + 9), 2'(i));
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            sb_q.push_back({2'(g), bitop_model(4'(g * 3 + 1), 4'(g + 9), 2'(g))});
            #1;
            tests_run++;
            if (req_ready !== 4'(1 << g)) begin
                tests_failed++;
                $display("FAIL rr_grant[%0d]: got %b, required %b", k, req_ready, 4'(1 << g));
            end
            tick();
            tests_run++;
            if (req_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL rr_exec_ready[%0d]: got %b, required 0000", k, req_ready);
            end
            tick();
            tests_run++;
            if ({rsp_valid, rsp_id, req_ready} !== {1'b1, 2'(g), 4'b0000}) begin
                tests_failed++;
                $display("FAIL rr_resp[%0d]: got valid=%b id=%0d ready=%b, required 1/%0d/0000",
                         k, rsp_valid, rsp_id, req_ready, g);
            end
            tick();
        end
        req_valid = '0;
        tests_run++;
        if (done_count !== 8'd5) begin
            tests_failed++;
            $display("FAIL rr_done_count: got %0d, required 5", done_count);
        end
    endtask

    task automatic test_backpressure();
        set_req(2, 4'b0110, 4'b0011, 2'b10);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        sb_q.push_back({2'd2, 4'b0101});
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL bp_grant: got %b, required 0100", req_ready);
        end
        tick();
        req_valid = 4'b1111;
        tick();
        for (int j = 0; j < 5; j++) begin
            #1;
            tests_run++;
            if ({rsp_valid, rsp_id, rsp_data, req_ready, done_count} !==
                {1'b1, 2'd2, 4'b0101, 4'b0000, 8'd5}) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got valid=%b id=%0d data=%b ready=%b cnt=%0d, required 1/2/0101/0000/5",
                         j, rsp_valid, rsp_id, rsp_data, req_ready, done_count);
            end
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release_valid: got %b, required 1", rsp_valid);
        end
        tick();
        tests_run++;
        if ({rsp_valid, done_count} !== {1'b0, 8'd6}) begin
            tests_failed++;
            $display("FAIL bp_after: got valid=%b cnt=%0d, required 0/6", rsp_valid, done_count);
        end
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_sb_drained: got %0d pending, required 0", sb_q.size());
        end
    endtask

    task automatic test_reset_exec();
        set_req(3, 4'b1001, 4'b0110, 2'b00);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b1000) begin
            tests_failed++;
            $display("FAIL rx_grant: got %b, required 1000", req_ready);
        end
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({rsp_valid, done_count} !== 9'd0) begin
            tests_failed++;
            $display("FAIL rx_after_reset: got valid=%b cnt=%0d, required 0/0", rsp_valid, done_count);
        end
        tick();
        tests_run++;
        if ({rsp_valid, done_count} !== 9'd0) begin
            tests_failed++;
            $display("FAIL rx_no_response: got valid=%b cnt=%0d, required 0/0", rsp_valid, done_count);
        end
        set_req(0, 4'b1111, 4'b0101, 2'b01);
        req_valid = 4'b1111;
        sb_q.push_back({2'd0, 4'b0101});
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rx_next_grant: got %b, required 0001", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 4'b0101}) begin
            tests_failed++;
            $display("FAIL rx_resp: got valid=%b id=%0d data=%b, required 1/0/0101",
                     rsp_valid, rsp_id, rsp_data);
        end
        tick();
        tests_run++;
        if (done_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL rx_done_count: got %0d, required 1", done_count);
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            set_req(0, 4'(n), 4'(n >> 2), 2'(n));
            sb_q.push_back({2'd0, bitop_model(4'(n), 4'(n >> 2), 2'(n))});
            tick();
            tick();
            tick();
            if (n == 255) begin
                tests_run++;
                if (done_count !== 8'd255) begin
                    tests_failed++;
                    $display("FAIL b2b_count_255: got %0d, required 255", done_count);
                end
            end
            if (n == 256) begin
                tests_run++;
                if (done_count !== 8'd0) begin
                    tests_failed++;
                    $display("FAIL b2b_count_wrap: got %0d, required 0", done_count);
                end
            end
        end
        req_valid = '0;
        tick();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_sb_drained: got %0d pending, required 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ops();
        test_round_robin();
        test_backpressure();
        test_reset_exec();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bitop_arbiter.md
BITOP_ARBITER -- requirements
Module: bitop_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the operand and result bit width.
REQ-002 Parameter NREQ, default 4, SHALL set the requester count; legal value is fixed at 4 (2-bit id).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 req_valid  input  NREQ  SHALL carry the per-requester request strobe.
REQ-006 req_ready  output  NREQ  SHALL carry the per-requester accept; at most one bit high per cycle.
REQ-007 req_a  input  NREQ*WIDTH  SHALL carry operand A; requester i uses bits [i*WIDTH +: WIDTH].
REQ-008 req_b  input  NREQ*WIDTH  SHALL carry operand B, packed as req_a.
REQ-009 req_op  input  NREQ*2  SHALL carry the opcode; requester i uses bits [i*2 +: 2].
REQ-010 rsp_valid  output  1  SHALL flag a valid result.
REQ-011 rsp_ready  input  1  SHALL be the consumer accept for the result.
REQ-012 rsp_id  output  2  SHALL carry the index of the requester that owns the result.
REQ-013 rsp_data  output  WIDTH  SHALL carry the registered result.
REQ-014 done_count  output  8  SHALL count completed responses.

Function
REQ-015 Opcodes SHALL be: 00 a|b, 01 a&b, 10 a^b, 11 ~a (b ignored).
REQ-016 FSM SHALL have states IDLE, EXEC, RESP.
REQ-017 In IDLE with any req_valid high, the block SHALL grant round-robin, searching from (last_grant+1) mod 4 upward with wrap.
REQ-018 In IDLE, req_ready[g] SHALL be high combinationally for the granted g only; all req_ready SHALL be 0 in EXEC and RESP.
REQ-019 On the accept cycle, the block SHALL latch a, b, op and id of g and go to EXEC.
REQ-020 Inputs SHALL be sampled only on the accept cycle; req_valid may drop before grant without effect.
REQ-021 EXEC SHALL compute the result into rsp_data/rsp_id and go to RESP, so that rsp_valid rises exactly 2 cycles after the accept edge.
REQ-022 In RESP, rsp_valid SHALL be 1, and rsp_data/rsp_id SHALL stay stable while rsp_ready is 0.
REQ-023 On rsp_valid && rsp_ready, the block SHALL set last_grant to rsp_id, increment done_count (255 wraps to 0), and go to IDLE.
REQ-024 Minimum spacing between accepts SHALL be 3 cycles; IDLE SHALL NOT accept in the same cycle as a response handshake.
REQ-025 With no req_valid in IDLE, the block SHALL stay in IDLE with all outputs unchanged.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE with last_grant=3 (requester 0 first), rsp_valid=0, rsp_id=0, rsp_data=0, done_count=0, and req_ready=0 during rst.
REQ-027 Reset in EXEC or RESP SHALL discard the in-flight transaction with no response and no done_count change.

Verification
REQ-028 Reset, then req_valid=0001, a0=1010, b0=1100, op0=00, rsp_ready=1 -> req_ready=0001 at cycle T; rsp_valid=1, rsp_id=0, rsp_data=1110 at T+2; done_count=1 after the handshake.
REQ-029 Requester 1 with a=1010, b=1100, ops 01/10/11 in sequence -> rsp_data 1000, 0110, 0101, all with rsp_id=1.
REQ-030 req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; accepts spaced 3 cycles apart.
REQ-031 rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id held; req_ready=0000 throughout; one handshake when rsp_ready=1.
REQ-032 rst=1 for one cycle while in EXEC -> next cycle IDLE, rsp_valid=0, done_count unchanged from 0 after reset, next grant goes to requester 0.
REQ-033 256 back-to-back transactions -> done_count reads 255 then 0.
